life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 SHALL have parameter W, default 32, meaning board width in cells.
REQ-002 SHALL have parameter H, default 24, meaning board height in cells; L = W*H is derived.
REQ-003 SHALL have parameter PERIOD, default 1000000, meaning clock cycles between generations in run mode; legal range is PERIOD >= 3.
REQ-004 SHALL have parameter CW, default 16, meaning generation counter width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port run, input, 1 bit: level; free-running generation mode.
REQ-008 SHALL have port step, input, 1 bit: single-cycle pulse; request one generation.
REQ-009 SHALL have port clear, input, 1 bit: single-cycle pulse; zero board and counter.
REQ-010 SHALL have port wr_valid, input, 1 bit: row-write request.
REQ-011 SHALL have port wr_ready, output, 1 bit: row-write accept.
REQ-012 SHALL have port wr_row, input, clog2(H) bits: target row index.
REQ-013 SHALL have port wr_data, input, W bits: row contents; bit c = column c.
REQ-014 SHALL have port next_in, input, L bits: registered successor board from the next-state stage.
REQ-015 SHALL have port board, output, L bits: current board; feeds the next-state stage and the display.
REQ-016 SHALL have port busy, output, 1 bit: generation commit in progress.
REQ-017 SHALL have port gen_count, output, CW bits: generations committed.
REQ-018 SHALL have ports stable, output, 1 bit (last commit left board unchanged), and extinct, output, 1 bit (board all zero).

Function
REQ-019 FSM SHALL have states IDLE, SETTLE, COMMIT; IDLE->SETTLE on trigger, SETTLE->COMMIT unconditionally, COMMIT->IDLE unconditionally.
REQ-020 Trigger SHALL be step=1 or pending tick, sampled in IDLE only; step in SETTLE/COMMIT SHALL be dropped.
REQ-021 In COMMIT: board <= next_in; gen_count <= gen_count+1, wrapping modulo 2^CW; stable <= (next_in == board).
REQ-022 Latency: trigger sampled at edge N -> new board visible after edge N+2; busy=1 exactly in SETTLE and COMMIT (2 cycles).
REQ-023 IDLE priority SHALL be clear > write > trigger; at most one of these actions per cycle.
REQ-024 clear in IDLE: board <= 0, gen_count <= 0, stable <= 0; clear outside IDLE SHALL be dropped.
REQ-025 wr_ready = 1 iff state is IDLE and clear = 0; a handshake (wr_valid & wr_ready) SHALL write board[wr_row*W +: W] = wr_data and set stable <= 0.
REQ-026 wr_row >= H SHALL be accepted (handshake completes) but SHALL NOT modify the board.
REQ-027 A write and a trigger in the same IDLE cycle: write wins; trigger (step or tick) SHALL be lost unless the tick remains pending per REQ-029.
REQ-028 Timer: counts 0..PERIOD-1 while run=1, held at 0 while run=0; tick fires on count==PERIOD-1.
REQ-029 Tick SHALL set a pending flag, cleared when consumed by an IDLE trigger or when run=0; a tick while busy SHALL NOT be lost.
REQ-030 extinct SHALL be combinational ~|board.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, board=0, gen_count=0, stable=0, timer=0, pending=0, in any state including SETTLE/COMMIT (a generation in flight is discarded).
REQ-032 Output values during and after reset: busy=0, wr_ready=1 (once rst deasserts), extinct=1.

Structure
REQ-033 Constants W, H, L and the FSM state enumeration SHALL live in shared package life_pkg.
REQ-034 Timer and pending flag SHALL be sub-module gen_timer (inputs clk, rst, run, consume; output pending).

Verification
Bench instantiates life_ctrl with the team's next-state stage, B=8'b0000_0100, S=8'b0000_0110, W=32, H=24.
REQ-035 Write row 5 = 0x0000_0038, step -> after 3 edges board holds vertical blinker (rows 4-6, column 4); gen_count=1, stable=0; second step restores horizontal form, gen_count=2.
REQ-036 Write 2x2 block at rows 0-1, columns 0-1, step -> board unchanged, stable=1, gen_count=1; a following write -> stable=0.
REQ-037 PERIOD=4, run=1 with blinker for 40 cycles -> gen_count increments every 4 cycles; hold step=1 throughout -> no extra generations while busy.
REQ-038 Same-cycle clear+wr_valid+step in IDLE -> board=0, gen_count=0, wr_ready=0 that cycle, no generation; write wr_row=30 -> handshake, board unchanged.
REQ-039 Assert rst during SETTLE -> next edge IDLE, board=0, gen_count=0, busy=0, extinct=1.
REQ-040 CW=2, four steps on blinker -> gen_count sequence 1,2,3,0.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared board geometry defaults and the generation FSM state encoding
package life_pkg;
  localparam int W = 32;
  localparam int H = 24;
  localparam int L = W * H;
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
endpackage

// File: rtl/life_ctrl_gen_timer.sv
// gen_timer: free-running generation timer (clk, rst, run, consume -> pending), pending holds a tick until consumed or run drops
module gen_timer #(
  parameter int PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic consume,
  output logic pending
);
  localparam int CNTW = $clog2(PERIOD);
  logic [CNTW-1:0] cnt;
  logic tick;
  assign tick = run & (cnt == CNTW'(PERIOD - 1));
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNTW'(1);
      pending <= tick | (pending & ~consume);
    end
  end
endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: Life board controller; row writes (wr_*), step/run triggers, clear, commits next_in into board and reports busy/gen_count/stable/extinct
module life_ctrl #(
  parameter int W = life_pkg::W,
  parameter int H = life_pkg::H,
  parameter int PERIOD = 1000000,
  parameter int CW = 16,
  localparam int L = W * H,
  localparam int RW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          clear,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_row,
  input  logic [W-1:0]  wr_data,
  input  logic [L-1:0]  next_in,
  output logic [L-1:0]  board,
  output logic          busy,
  output logic [CW-1:0] gen_count,
  output logic          stable,
  output logic          extinct
);
  import life_pkg::*;
  state_t state, state_n;
  logic idle, wr_go, go, pending;
  assign idle = state == IDLE;
  assign wr_ready = idle & ~clear;
  assign wr_go = wr_valid & wr_ready;
  assign go = idle & ~clear & ~wr_valid & (step | pending);
  assign busy = ~idle;
  assign extinct = ~|board;
  gen_timer #(.PERIOD(PERIOD)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(run),
    .consume(go),
    .pending(pending)
  );
  always_comb begin
    state_n = idle ? (go ? SETTLE : IDLE) : (state == SETTLE) ? COMMIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      board <= '0;
      gen_count <= '0;
      stable <= 1'b0;
    end else begin
      state <= state_n;
      if (idle && clear) begin
        board <= '0;
        gen_count <= '0;
        stable <= 1'b0;
      end else if (wr_go) begin
        if (int'(wr_row) < H) board[int'(wr_row) * W +: W] <= wr_data;
        stable <= 1'b0;
      end else if (state == COMMIT) begin
        board <= next_in;
        gen_count <= gen_count + CW'(1);
        stable <= next_in == board;
      end
    end
  end
endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: scoreboard bench for life_ctrl with a registered Life next-state stage (CW=16 and CW=2 instances)
module tb_life_ctrl;
  localparam int W = 32;
  localparam int H = 24;
  localparam int L = W * H;
  localparam logic [7:0] B = 8'b0000_0100;
  localparam logic [7:0] S = 8'b0000_0110;
  typedef struct {
    logic [L-1:0] b;
    logic [15:0] g;
    logic s;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic step = 1'b0;
  logic clear = 1'b0;
  logic wr_valid = 1'b0;
  logic [4:0] wr_row = '0;
  logic [W-1:0] wr_data = '0;
  logic wr_ready0, wr_ready1, busy0, busy1, stable0, stable1, extinct0, extinct1;
  logic [L-1:0] board0, board1, nx0, nx1, bh, bv, blk;
  logic [15:0] gen0;
  logic [1:0] gen1;
  logic pb;
  always #5 clk = ~clk;
  life_ctrl #(.W(W), .H(H), .PERIOD(4), .CW(16)) u0 (
    .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_row(wr_row), .wr_data(wr_data),
    .next_in(nx0), .board(board0), .busy(busy0), .gen_count(gen0),
    .stable(stable0), .extinct(extinct0)
  );
  life_ctrl #(.W(W), .H(H), .PERIOD(4), .CW(2)) u1 (
    .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_row(wr_row), .wr_data(wr_data),
    .next_in(nx1), .board(board1), .busy(busy1), .gen_count(gen1),
    .stable(stable1), .extinct(extinct1)
  );
  function automatic logic [L-1:0] life(input logic [L-1:0] b);
    logic [L-1:0] o;
    int n;
    o = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              n += int'(b[(r + dr) * W + c + dc]);
        o[r * W + c] = (n >= 1) && (b[r * W + c] ? S[n - 1] : B[n - 1]);
      end
    return o;
  endfunction
  always @(posedge clk) begin
    nx0 <= life(board0);
    nx1 <= life(board1);
  end
  function automatic logic [L-1:0] rowb(input int r, input logic [W-1:0] d);
    logic [L-1:0] b;
    b = '0;
    b[r * W +: W] = d;
    return b;
  endfunction
  task automatic chk(input string n, input logic [L-1:0] got, input logic [L-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask
  task automatic push(input logic [L-1:0] b, input int g, input logic s);
    exp_t e;
    e.b = b;
    e.g = 16'(g);
    e.s = s;
    q.push_back(e);
  endtask
  task automatic wr(input int r, input logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_row = 5'(r);
    wr_data = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask
  task automatic do_step();
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pb && !busy0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected got gen %0d exp none", gen0);
      end else begin
        e = q.pop_front();
        chk("commit_board", board0, e.b);
        chk("commit_gen", gen0, e.g);
        chk("commit_stable", stable0, e.s);
        chk("commit_gen_cw2", gen1, e.g[1:0]);
        chk("commit_board_cw2", board1, e.b);
      end
    end
    pb = busy0;
  end
  initial begin
    bh = rowb(5, 32'h38);
    bv = rowb(4, 32'h10) | rowb(5, 32'h10) | rowb(6, 32'h10);
    blk = rowb(0, 32'h3) | rowb(1, 32'h3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_extinct", extinct0, 1);
    chk("rst_board", board0, 0);
    chk("rst_gen", gen0, 0);
    chk("rst_stable", stable0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready0, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) push((i % 2) ? bv : bh, i, 1'b0);
    wr(5, 32'h38);
    for (int i = 0; i < 4; i++) do_step();
    clear = 1'b1;
    wr_valid = 1'b1;
    wr_row = 5'd5;
    wr_data = '1;
    step = 1'b1;
    @(negedge clk);
    chk("clr_wr_ready", wr_ready0, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    wr_valid = 1'b0;
    step = 1'b0;
    @(negedge clk);
    chk("clr_board", board0, 0);
    chk("clr_gen", gen0, 0);
    chk("clr_gen_cw2", gen1, 0);
    chk("clr_busy", busy0, 0);
    repeat (3) @(posedge clk);
    #1 wr_valid = 1'b1;
    wr_row = 5'd30;
    wr_data = '1;
    @(negedge clk);
    chk("row30_wr_ready", wr_ready0, 1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("row30_board", board0, 0);
    chk("row30_extinct", extinct0, 1);
    @(posedge clk);
    #1;
    push(blk, 1, 1'b1);
    wr(0, 32'h3);
    wr(1, 32'h3);
    do_step();
    wr(10, 32'h0);
    @(negedge clk);
    chk("block_wr_stable", stable0, 0);
    chk("block_wr_board", board0, blk);
    @(posedge clk);
    #1;
    pulse_clear();
    wr(5, 32'h38);
    for (int i = 1; i <= 9; i++) push((i % 2) ? bv : bh, i, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 38; i++) begin
      @(posedge clk);
      if (i == 20) begin
        @(negedge clk);
        chk("run_mid_gen", gen0, 4);
      end
    end
    #1 run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pulse_clear();
    wr(5, 32'h38);
    for (int i = 1; i <= 13; i++) push((i % 2) ? bv : bh, i, 1'b0);
    run = 1'b1;
    step = 1'b1;
    for (int i = 0; i < 39; i++) @(posedge clk);
    #1 run = 1'b0;
    step = 1'b0;
    repeat (4) @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(negedge clk);
    chk("settle_busy", busy0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_board", board0, 0);
    chk("mid_rst_gen", gen0, 0);
    chk("mid_rst_gen_cw2", gen1, 0);
    chk("mid_rst_extinct", extinct0, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_board", board0, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
